// File: rtl/wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM bridge and sibling
// Wishbone slaves: cycle-type codes, controller state encoding, and the
// payload latched when a request is accepted.
package wb_sram_ctrl_pkg;

    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 4;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_ACK      = 3'd5
    } state_e;

    // Write payload captured together with the address in IDLE
    typedef struct packed {
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } wr_req_t;

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave driving a 32-bit asynchronous SRAM.
// Ports:
//   sys_clk / sys_rst            clock, asynchronous active-low reset
//   wb_*                         Wishbone slave (classic + incrementing read bursts)
//   sram_adr_o / sram_d_o        word address and write data to the pads
//   sram_d_i / sram_d_oe         read data from pads, pad drive enable
//   sram_ce_n/oe_n/we_n/be_n     active-low SRAM strobes
// All outputs are registered; strobe flops are loaded from the next state so
// each state's strobe pattern appears exactly in the cycles spent there.
module wb_sram_ctrl
    import wb_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADR_W   = 18,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [31:0]      wb_adr_i,
    input  logic [DAT_W-1:0] wb_dat_i,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [SEL_W-1:0] wb_sel_i,
    input  logic [2:0]       wb_cti_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    output logic [ADR_W-1:0] sram_adr_o,
    input  logic [DAT_W-1:0] sram_d_i,
    output logic [DAT_W-1:0] sram_d_o,
    output logic             sram_d_oe,
    output logic             sram_ce_n,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic [SEL_W-1:0] sram_be_n
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    wr_req_t          req_q, req_d;
    logic [DAT_W-1:0] rdat_q, rdat_d;
    logic             ack_q, ack_d;
    logic             ce_n_q, ce_n_d;
    logic             oe_n_q, oe_n_d;
    logic             we_n_q, we_n_d;
    logic             d_oe_q, d_oe_d;
    logic [SEL_W-1:0] be_n_q, be_n_d;

    // Byte-lane bits and bits above the SRAM window are not decoded
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:ADR_W+2], wb_adr_i[1:0]};

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            req_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            d_oe_q  <= 1'b0;
            be_n_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            req_q   <= req_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            d_oe_q  <= d_oe_d;
            be_n_q  <= be_n_d;
        end
    end

    // Next-state, datapath and strobe decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        req_d   = req_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        d_oe_d  = 1'b0;
        be_n_d  = '1;

        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d     = wb_adr_i[ADR_W+1:2];
                    req_d.dat = wb_dat_i;
                    req_d.sel = wb_sel_i;
                    cnt_d     = CNT_W'(RD_WAIT);
                    state_d   = wb_we_i ? ST_WR_SETUP : ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!wb_cyc_i) begin
                    // Master gave up: finish quietly, no ack, no continuation
                    state_d = ST_IDLE;
                end else begin
                    ack_d  = 1'b1;
                    rdat_d = sram_d_i;
                    if (wb_cti_i == CTI_INCR) begin
                        // Next beat starts in the ack cycle; address wraps naturally
                        adr_d = adr_q + ADR_W'(1);
                        cnt_d = CNT_W'(RD_WAIT);
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = CNT_W'(WR_WAIT);
            end
            ST_WR_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_WR_HOLD;
                    ack_d   = wb_cyc_i;
                end
            end
            ST_WR_HOLD: state_d = ST_IDLE;
            ST_ACK:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Strobe pattern belongs to the state being entered
        case (state_d)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d = 1'b0;
                d_oe_d = 1'b1;
                be_n_d = ~req_d.sel;
            end
            ST_WR_PULSE: begin
                ce_n_d = 1'b0;
                we_n_d = 1'b0;
                d_oe_d = 1'b1;
                be_n_d = ~req_d.sel;
            end
            default: ;
        endcase
    end

    assign wb_dat_o   = rdat_q;
    assign wb_ack_o   = ack_q;
    assign sram_adr_o = adr_q;
    assign sram_d_o   = req_q.dat;
    assign sram_d_oe  = d_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench for wb_sram_ctrl: behavioural async SRAM device plus an
// expected-memory reference model; latencies derived from the wait parameters.
module tb_wb_sram_ctrl;
    import wb_sram_ctrl_pkg::*;

    localparam int ADR_W   = 18;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam int TR      = 64;
    localparam int NWORDS  = 1 << ADR_W;

    logic             sys_clk, sys_rst;
    logic [31:0]      wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]       wb_sel_i;
    logic [2:0]       wb_cti_i;
    logic             wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
    logic [ADR_W-1:0] sram_adr_o;
    logic [31:0]      sram_d_i, sram_d_o;
    logic             sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]       sram_be_n;

    wb_sram_ctrl #(.ADR_W(ADR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_cti_i(wb_cti_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .sram_adr_o(sram_adr_o), .sram_d_i(sram_d_i), .sram_d_o(sram_d_o),
        .sram_d_oe(sram_d_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural asynchronous SRAM device
    logic [31:0] sram_mem [NWORDS];
    logic [31:0] exp_mem  [NWORDS];
    assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_adr_o] : 32'h0;
    always @(posedge sys_clk)
        if (!sram_ce_n && !sram_we_n && sram_d_oe)
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) sram_mem[sram_adr_o][8*b +: 8] <= sram_d_o[8*b +: 8];

    int checks = 0;
    int failures = 0;

    // Per-cycle trace of the last transaction (cycle 0 = stb asserted)
    logic             tr_ack[TR], tr_ce[TR], tr_oe[TR], tr_we[TR], tr_doe[TR];
    logic [3:0]       tr_be[TR];
    logic [ADR_W-1:0] tr_adr[TR];
    int               tr_len;
    int               ack_cyc[$];
    logic [31:0]      rd_dat[$];

    function automatic logic [63:0] range_mask(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // which: 0 ce_n low, 1 oe_n low, 2 we_n low, 3 d_oe high
    function automatic logic [63:0] trace_mask(input int which);
        logic [63:0] m = '0;
        for (int k = 0; k < tr_len; k++)
            case (which)
                0: m[k] = (tr_ce[k] == 1'b0);
                1: m[k] = (tr_oe[k] == 1'b0);
                2: m[k] = (tr_we[k] == 1'b0);
                default: m[k] = (tr_doe[k] == 1'b1);
            endcase
        return m;
    endfunction

    function automatic int exp_ack(input bit we, input int beat);
        return we ? WR_WAIT + 3 : RD_WAIT + 2 + beat * (RD_WAIT + 1);
    endfunction

    function automatic logic [ADR_W-1:0] word_of(input logic [31:0] adr);
        return ADR_W'(adr >> 2);
    endfunction

    task automatic model_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        for (int b = 0; b < 4; b++)
            if (sel[b]) exp_mem[word_of(adr)][8*b +: 8] = dat[8*b +: 8];
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = CTI_CLASSIC;
    endtask

    task automatic record(input int k);
        tr_ack[k] = wb_ack_o; tr_ce[k] = sram_ce_n; tr_oe[k] = sram_oe_n;
        tr_we[k] = sram_we_n; tr_doe[k] = sram_d_oe; tr_be[k] = sram_be_n;
        tr_adr[k] = sram_adr_o;
    endtask

    // Wishbone master: called at posedge+1; the calling cycle is cycle 0.
    // drop_at >= 0 deasserts cyc/stb in that cycle.
    task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int beats, input int drop_at);
        bit pend = 1'b0;
        int done_at = -1;
        ack_cyc.delete(); rd_dat.delete();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = dat; wb_sel_i = sel;
        wb_cti_i = (beats > 1) ? CTI_INCR : CTI_CLASSIC;
        record(0);
        tr_len = 1;
        for (int k = 1; k < TR; k++) begin
            @(posedge sys_clk); #1;
            if (pend) begin
                pend = 1'b0;
                if (ack_cyc.size() >= beats) begin
                    idle_bus(); done_at = k;
                end else begin
                    wb_adr_i = wb_adr_i + 32'd4;
                    wb_cti_i = (ack_cyc.size() == beats - 1) ? CTI_END : CTI_INCR;
                end
            end
            if (k == drop_at) begin
                idle_bus(); done_at = k;
            end
            record(k);
            tr_len = k + 1;
            if (wb_ack_o) begin
                ack_cyc.push_back(k); rd_dat.push_back(wb_dat_o);
                if (done_at < 0) pend = 1'b1;
            end
            if (done_at >= 0 && k >= done_at + 6) break;
        end
        if (done_at < 0) idle_bus();
    endtask

    task automatic test_reset();
        sys_rst = 1'b0; idle_bus(); wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
        checks++; if (wb_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin failures++; $display("FAIL reset_strobes: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
        checks++; if (sram_be_n !== 4'hF) begin failures++; $display("FAIL reset_be: got %h want f", sram_be_n); end
        checks++; if (sram_d_oe !== 1'b0) begin failures++; $display("FAIL reset_doe: got %b want 0", sram_d_oe); end
        checks++; if (sram_adr_o !== '0 || sram_d_o !== 32'h0) begin failures++; $display("FAIL reset_adr_dat: got %h/%h want 0/0", sram_adr_o, sram_d_o); end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, -1);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (ack_cyc.size() != 1 || ack_cyc[0] != exp_ack(1'b1, 0)) begin failures++; $display("FAIL write_ack: got %0d acks first %0d want 1 at %0d", ack_cyc.size(), ack_cyc.size() ? ack_cyc[0] : -1, exp_ack(1'b1, 0)); end
        checks++; if (trace_mask(2) !== range_mask(2, WR_WAIT + 2)) begin failures++; $display("FAIL write_we_n: got %h want %h", trace_mask(2), range_mask(2, WR_WAIT + 2)); end
        checks++; if (trace_mask(3) !== range_mask(1, WR_WAIT + 3)) begin failures++; $display("FAIL write_doe: got %h want %h", trace_mask(3), range_mask(1, WR_WAIT + 3)); end
        checks++; if (tr_adr[3] !== ADR_W'(4) || tr_be[3] !== 4'h0) begin failures++; $display("FAIL write_adr_be: got %h/%h want 4/0", tr_adr[3], tr_be[3]); end
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, 1, -1);
        checks++; if (trace_mask(1) !== range_mask(1, RD_WAIT + 1)) begin failures++; $display("FAIL read_oe_n: got %h want %h", trace_mask(1), range_mask(1, RD_WAIT + 1)); end
        checks++; if (ack_cyc.size() != 1 || ack_cyc[0] != exp_ack(1'b0, 0)) begin failures++; $display("FAIL read_ack: got %0d acks first %0d want 1 at %0d", ack_cyc.size(), ack_cyc.size() ? ack_cyc[0] : -1, exp_ack(1'b0, 0)); end
        checks++; if (rd_dat.size() != 1 || rd_dat[0] !== exp_mem[4]) begin failures++; $display("FAIL read_data: got %h want %h", rd_dat.size() ? rd_dat[0] : 32'hx, exp_mem[4]); end
        checks++; if (tr_be[2] !== 4'h0 || tr_doe[2] !== 1'b0) begin failures++; $display("FAIL read_be_doe: got %h/%b want 0/0", tr_be[2], tr_doe[2]); end
    endtask

    task automatic test_byte_write();
        logic [31:0] want = 32'hDE22BEEF;
        run_txn(1'b1, 32'h10, 32'h11223344, 4'b0100, 1, -1);
        model_write(32'h10, 32'h11223344, 4'b0100);
        checks++; if (tr_be[3] !== 4'b1011) begin failures++; $display("FAIL bytewr_be: got %b want 1011", tr_be[3]); end
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, 1, -1);
        checks++; if (rd_dat.size() != 1 || rd_dat[0] !== exp_mem[4] || rd_dat[0] !== want) begin failures++; $display("FAIL bytewr_data: got %h want %h", rd_dat.size() ? rd_dat[0] : 32'hx, want); end
    endtask

    task automatic test_burst();
        int bad = 0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d = $urandom;
            run_txn(1'b1, 32'h100 + 32'(4 * i), d, 4'hF, 1, -1);
            model_write(32'h100 + 32'(4 * i), d, 4'hF);
        end
        run_txn(1'b0, 32'h100, 32'h0, 4'hF, 4, -1);
        checks++; if (ack_cyc.size() != 4) begin failures++; $display("FAIL burst_ack_count: got %0d want 4", ack_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            int got = (i < ack_cyc.size()) ? ack_cyc[i] : -1;
            logic [31:0] gd = (i < rd_dat.size()) ? rd_dat[i] : 32'hx;
            checks++; if (got != exp_ack(1'b0, i)) begin failures++; $display("FAIL burst_ack_cycle%0d: got %0d want %0d", i, got, exp_ack(1'b0, i)); end
            checks++; if (gd !== exp_mem[ADR_W'(32'h40 + i)]) begin failures++; $display("FAIL burst_data%0d: got %h want %h", i, gd, exp_mem[ADR_W'(32'h40 + i)]); end
            if (tr_adr[1 + i * (RD_WAIT + 1)] !== ADR_W'(32'h40 + i)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL burst_adr: got %0d wrong beat addresses want 0", bad); end
        checks++; if (trace_mask(0) !== range_mask(1, 4 * (RD_WAIT + 1))) begin failures++; $display("FAIL burst_ce_n: got %h want %h", trace_mask(0), range_mask(1, 4 * (RD_WAIT + 1))); end
    endtask

    task automatic test_wrap();
        logic [31:0] top_adr = 32'((NWORDS - 1) * 4);
        logic [31:0] d0 = $urandom, d1 = $urandom;
        run_txn(1'b1, top_adr, d0, 4'hF, 1, -1); model_write(top_adr, d0, 4'hF);
        run_txn(1'b1, 32'h0, d1, 4'hF, 1, -1);   model_write(32'h0, d1, 4'hF);
        run_txn(1'b0, top_adr, 32'h0, 4'hF, 2, -1);
        checks++; if (tr_adr[RD_WAIT + 2] !== '0) begin failures++; $display("FAIL wrap_adr: got %h want 0", tr_adr[RD_WAIT + 2]); end
        checks++; if (rd_dat.size() != 2 || rd_dat[0] !== exp_mem[NWORDS - 1] || rd_dat[1] !== exp_mem[0]) begin failures++; $display("FAIL wrap_data: got %0d beats %h %h want %h %h", rd_dat.size(), rd_dat.size() > 0 ? rd_dat[0] : 32'hx, rd_dat.size() > 1 ? rd_dat[1] : 32'hx, exp_mem[NWORDS - 1], exp_mem[0]); end
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h8000;
        wb_dat_i = 32'hCAFEF00D; wb_sel_i = 4'hF; wb_cti_i = CTI_CLASSIC;
        repeat (3) begin @(posedge sys_clk); #1; if (wb_ack_o) acks++; end
        checks++; if (sram_we_n !== 1'b0) begin failures++; $display("FAIL rstwr_in_pulse: got we_n %b want 0", sram_we_n); end
        #2 sys_rst = 1'b0;
        #1;
        checks++; if ({sram_we_n, sram_ce_n, sram_d_oe} !== 3'b110) begin failures++; $display("FAIL rstwr_async: got we_n/ce_n/doe %b want 110", {sram_we_n, sram_ce_n, sram_d_oe}); end
        idle_bus();
        repeat (2) begin @(posedge sys_clk); #1; if (wb_ack_o) acks++; end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1; if (wb_ack_o) acks++;
        checks++; if (acks != 0) begin failures++; $display("FAIL rstwr_no_ack: got %0d acks want 0", acks); end
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, 1, -1);
        checks++; if (ack_cyc.size() != 1 || ack_cyc[0] != exp_ack(1'b0, 0)) begin failures++; $display("FAIL rstwr_fresh_read: got %0d acks first %0d want 1 at %0d", ack_cyc.size(), ack_cyc.size() ? ack_cyc[0] : -1, exp_ack(1'b0, 0)); end
    endtask

    task automatic test_cyc_drop();
        run_txn(1'b0, 32'h10, 32'h0, 4'hF, 1, 2);
        checks++; if (ack_cyc.size() != 0) begin failures++; $display("FAIL drop_rd_ack: got %0d acks want 0", ack_cyc.size()); end
        checks++; if (trace_mask(1) !== range_mask(1, RD_WAIT + 1)) begin failures++; $display("FAIL drop_rd_oe_n: got %h want %h", trace_mask(1), range_mask(1, RD_WAIT + 1)); end
        run_txn(1'b1, 32'h14, 32'h5A5A5A5A, 4'hF, 1, 3);
        model_write(32'h14, 32'h5A5A5A5A, 4'hF);
        checks++; if (ack_cyc.size() != 0) begin failures++; $display("FAIL drop_wr_ack: got %0d acks want 0", ack_cyc.size()); end
        checks++; if (trace_mask(2) !== range_mask(2, WR_WAIT + 2)) begin failures++; $display("FAIL drop_wr_we_n: got %h want %h", trace_mask(2), range_mask(2, WR_WAIT + 2)); end
        run_txn(1'b0, 32'h14, 32'h0, 4'hF, 1, -1);
        checks++; if (ack_cyc.size() != 1 || ack_cyc[0] != exp_ack(1'b0, 0) || rd_dat[0] !== exp_mem[5]) begin failures++; $display("FAIL drop_next_txn: got %0d acks data %h want 1 ack data %h", ack_cyc.size(), rd_dat.size() ? rd_dat[0] : 32'hx, exp_mem[5]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            bit          we    = 1'($urandom_range(0, 1));
            int          w     = $urandom_range(0, 12);
            int          beats = we ? 1 : $urandom_range(1, 4);
            logic [31:0] dat   = $urandom;
            logic [3:0]  sel   = 4'($urandom_range(1, 15));
            int bad_lat = 0, bad_dat = 0, bad_inv = 0;
            run_txn(we, 32'(w * 4), dat, sel, beats, -1);
            if (we) model_write(32'(w * 4), dat, sel);
            for (int i = 0; i < ack_cyc.size() && i < beats; i++) begin
                if (ack_cyc[i] != exp_ack(we, i)) bad_lat++;
                if (!we && rd_dat[i] !== exp_mem[w + i]) bad_dat++;
            end
            for (int k = 0; k < tr_len; k++) begin
                if (tr_oe[k] == 1'b0 && (tr_we[k] == 1'b0 || tr_doe[k] == 1'b1)) bad_inv++;
                if (k > 0 && tr_ack[k] && tr_ack[k - 1]) bad_inv++;
            end
            checks++; if (ack_cyc.size() != beats) begin failures++; $display("FAIL rand%0d_ack_count: got %0d want %0d", n, ack_cyc.size(), beats); end
            checks++; if (bad_lat != 0 || bad_dat != 0) begin failures++; $display("FAIL rand%0d_lat_data: got %0d latency and %0d data errors want 0", n, bad_lat, bad_dat); end
            checks++; if (bad_inv != 0) begin failures++; $display("FAIL rand%0d_strobe_rules: got %0d violations want 0", n, bad_inv); end
        end
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            sram_mem[i] = 32'h0;
            exp_mem[i]  = 32'h0;
        end
        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_burst();
        test_wrap();
        test_reset_mid_write();
        test_cyc_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
